// File: rtl/arb_pkg.sv
// Shared types and sizing for the round-robin arbiter.
// Requester count is derived from the grant index width and is not overridable.
package arb_pkg;

    localparam int ID_W = 4;
    localparam int N    = 1 << ID_W;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Assumes at most one bit set; an all-zero vector maps to index 0.
    function automatic logic [ID_W-1:0] onehot2bin(input logic [N-1:0] oh);
        logic [ID_W-1:0] b;
        b = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) begin
                b = b | ID_W'(i);
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/rr_prio_encoder.sv
// Round-robin priority encoder: lowest eligible requester at or above ptr,
// wrapping to the lowest eligible requester overall when none is above.
module rr_prio_encoder
    import arb_pkg::*;
(
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic [N-1:0]    excl,
    output logic [ID_W-1:0] winner,
    output logic            found
);

    logic [N-1:0]    eligible;
    logic [N-1:0]    hi_mask;
    logic [N-1:0]    upper;
    logic [ID_W-1:0] lo_idx;
    logic [ID_W-1:0] hi_idx;
    logic            lo_found;
    logic            hi_found;

    assign eligible = req & ~excl;
    assign hi_mask  = ~((N'(1) << ptr) - N'(1));
    assign upper    = eligible & hi_mask;

    // Descending scan so the last hit, i.e. the lowest index, wins.
    always_comb begin
        lo_idx   = '0;
        hi_idx   = '0;
        lo_found = 1'b0;
        hi_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                lo_idx   = ID_W'(i);
                lo_found = 1'b1;
            end
            if (upper[i]) begin
                hi_idx   = ID_W'(i);
                hi_found = 1'b1;
            end
        end
    end

    assign winner = hi_found ? hi_idx : lo_idx;
    assign found  = lo_found;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, binary index and an
// optional hold limit that forces rotation away from a long-running owner.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_valid,
    output logic            preempt
);

    localparam int              HC_W     = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(MAX_HOLD);

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;
    logic            gnt_valid_q, gnt_valid_d;
    logic            preempt_q, preempt_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [HC_W-1:0] hold_q, hold_d;

    logic [ID_W-1:0] winner;
    logic            found;
    logic            owner_holds;
    logic            grant_new;
    logic            go_idle;

    // Excluding the current owner covers both release hand-off and preemption;
    // in IDLE gnt_q is zero so nothing is excluded.
    rr_prio_encoder u_enc (
        .req    (req),
        .ptr    (ptr_q),
        .excl   (gnt_q),
        .winner (winner),
        .found  (found)
    );

    assign owner_holds = |(req & gnt_q);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        grant_new = 1'b0;
        go_idle   = 1'b0;

        if (!en) begin
            go_idle = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    grant_new = found;
                end
                GRANT: begin
                    if (!owner_holds) begin
                        grant_new = found;
                        go_idle   = !found;
                    end else if (MAX_HOLD != 0 && hold_q == HOLD_LIM) begin
                        if (found) begin
                            grant_new = 1'b1;
                            preempt_d = 1'b1;
                        end else begin
                            hold_d = HC_W'(1);
                        end
                    end else if (MAX_HOLD != 0) begin
                        hold_d = hold_q + HC_W'(1);
                    end
                end
                default: go_idle = 1'b1;
            endcase
        end

        if (grant_new) begin
            state_d = GRANT;
            gnt_d   = N'(1) << winner;
            ptr_d   = winner + ID_W'(1);
            hold_d  = HC_W'(1);
        end else if (go_idle) begin
            state_d = IDLE;
            gnt_d   = '0;
            hold_d  = '0;
        end

        gnt_id_d    = onehot2bin(gnt_d);
        gnt_valid_d = |gnt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
            ptr_q       <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            preempt_q   <= preempt_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: directed grant events checked against a
// queue of expected events, then random traffic with invariant/fairness checks.
module tb_rr_arbiter;
    import arb_pkg::*;

    localparam int MAX_HOLD   = 4;
    localparam int WAIT_LIMIT = N * MAX_HOLD;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    gnt;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_valid;
    logic            preempt;

    typedef struct {
        logic valid;
        int   id;
        logic pre;
        int   at;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    bit           rnd_mode = 1'b0;
    logic [N-1:0] prev_gnt = '0;
    logic [N-1:0] prev_req = '0;
    logic         prev_en = 1'b0;
    int           wait_cnt[N];
    int           worst;

    rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int req_val);
        checks++;
        if (act !== req_val) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req_val, req_val, cyc);
        end
    endfunction

    function automatic int idx_of(logic [N-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic void push_exp(logic v, int id, logic p, int at);
        exp_t e;
        e.valid = v;
        e.id    = id;
        e.pre   = p;
        e.at    = at;
        exp_q.push_back(e);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("onehot", int'($onehot0(gnt)), 1);
                chk("valid_match", int'(gnt_valid), int'(|gnt));
                chk("id_match", int'(gnt_id), idx_of(gnt));
                if (gnt_valid) chk("grant_legal", int'(prev_en && prev_req[gnt_id]), 1);
                if (preempt) chk("preempt_valid", int'(gnt_valid), 1);

                if (!rnd_mode) begin
                    if (gnt !== prev_gnt || preempt) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_event: got gnt=0x%0h preempt=%0b, expected no change at cycle %0d",
                                     gnt, preempt, cyc);
                        end else begin
                            e = exp_q.pop_front();
                            $display("txn cyc=%0d gnt=0x%04h id=%0d valid=%0b preempt=%0b",
                                     cyc, gnt, gnt_id, gnt_valid, preempt);
                            chk("evt_cycle", cyc, e.at);
                            chk("evt_valid", int'(gnt_valid), int'(e.valid));
                            chk("evt_id", int'(gnt_id), e.valid ? e.id : 0);
                            chk("evt_gnt", int'(gnt), e.valid ? (1 << e.id) : 0);
                            chk("evt_preempt", int'(preempt), int'(e.pre));
                        end
                    end else if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                        e = exp_q.pop_front();
                        chk("evt_missing", cyc + 1000, e.at);
                    end
                end else begin
                    worst = 0;
                    for (int i = 0; i < N; i++) begin
                        if (req[i] && en && gnt_valid && !gnt[i]) wait_cnt[i]++;
                        else if (!req[i] || gnt[i]) wait_cnt[i] = 0;
                        if (wait_cnt[i] > worst) worst = wait_cnt[i];
                    end
                    chk("fair_wait_ok", int'(worst <= WAIT_LIMIT), 1);
                end
            end
            prev_gnt = gnt;
            prev_req = req;
            prev_en  = en;
        end
    end

    initial begin
        // 1. reset values, async reset mid-grant, grant after release
        step();
        step();
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_gnt_id", int'(gnt_id), 0);
        chk("rst_valid", int'(gnt_valid), 0);
        chk("rst_preempt", int'(preempt), 0);
        rst_n = 1'b1;
        en    = 1'b1;
        req   = 16'h0001;
        push_exp(1'b1, 0, 1'b0, cyc + 1);
        step();
        step();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_gnt", int'(gnt), 0);
        chk("rst_async_valid", int'(gnt_valid), 0);
        chk("rst_async_id", int'(gnt_id), 0);
        step();
        rst_n = 1'b1;
        push_exp(1'b1, 0, 1'b0, cyc + 1);
        step();
        req = '0;
        push_exp(1'b0, 0, 1'b0, cyc + 1);
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // 2. full rotation 0..15 and wrap back to 0
        step();
        req = 16'hFFFF;
        push_exp(1'b1, 0, 1'b0, cyc + 1);
        for (int i = 0; i < N; i++) begin
            step();
            req = 16'hFFFF & ~(16'h0001 << i);
            push_exp(1'b1, (i + 1) % N, 1'b0, cyc + 1);
        end
        step();
        req = '0;
        push_exp(1'b0, 0, 1'b0, cyc + 1);

        // 3. release hand-off 3 -> 7 with no idle gap (ptr is 1 here)
        step();
        req = 16'h0088;
        push_exp(1'b1, 3, 1'b0, cyc + 1);
        step();
        req = 16'h0080;
        push_exp(1'b1, 7, 1'b0, cyc + 1);
        step();
        req = '0;
        push_exp(1'b0, 0, 1'b0, cyc + 1);

        // 4. hold-limit preemption 2 -> 9, then lone owner at limit keeps grant
        step();
        req = 16'h0004;
        push_exp(1'b1, 2, 1'b0, cyc + 1);
        step();
        req = 16'h0204;
        push_exp(1'b1, 9, 1'b1, cyc + 4);
        repeat (4) step();
        req = 16'h0200;
        repeat (10) step();
        req = '0;
        push_exp(1'b0, 0, 1'b0, cyc + 1);

        // 5. en low drops grant; ptr survives (ptr 10 -> grant 4 -> ptr 5)
        step();
        req = 16'h0010;
        push_exp(1'b1, 4, 1'b0, cyc + 1);
        step();
        en = 1'b0;
        push_exp(1'b0, 0, 1'b0, cyc + 1);
        step();
        step();
        en  = 1'b1;
        req = 16'h0030;
        push_exp(1'b1, 5, 1'b0, cyc + 1);
        step();
        req = '0;
        push_exp(1'b0, 0, 1'b0, cyc + 1);
        step();
        step();

        // 6. random sticky traffic with random enable
        rnd_mode = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            step();
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            end
            en = ($urandom_range(0, 31) != 0);
        end
        step();
        en  = 1'b0;
        req = '0;
        repeat (3) step();
        rnd_mode = 1'b0;
        step();

        chk("sb_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
